stim_sequencer: RTL and testbench
=================================

STIM_SEQUENCER -- requirements
Module: stim_sequencer

Interface
REQ-001 Parameter IN_W, default 335, DUT input vector width.
REQ-002 Parameter OUT_W, default 412, DUT output vector width.
REQ-003 Parameter RST_CYCLES, default 2, DUT reset hold length in cycles; legal values are 1 or greater.
REQ-004 Port clk  input  1  single clock; all logic SHALL be rising-edge.
REQ-005 Port rst  input  1  synchronous, active-high reset.
REQ-006 Port start  input  1  single-cycle run request; only sampled in IDLE.
REQ-007 Port seed  input  32  LCG seed, captured when start is accepted.
REQ-008 Port num_vectors  input  16  vectors per run, captured when start is accepted.
REQ-009 Port dut_rst_n  output  1  active-low reset to the DUT.
REQ-010 Port dut_in  output  IN_W  stimulus vector to the DUT.
REQ-011 Port dut_out  input  OUT_W  DUT response.
REQ-012 Port busy  output  1  high in every state except IDLE.
REQ-013 Port done  output  1  one-cycle pulse at the end of a run.
REQ-014 Port vec_count  output  16  number of vectors applied in the current or last run.
REQ-015 Port signature  output  32  response signature (MISR).

Function
REQ-016 FSM states SHALL be IDLE, DUT_RST, FILL, APPLY, SAMPLE and DONE.
REQ-017 IDLE: on start=1, capture seed and num_vectors, clear vec_count and signature to 0, and go to DUT_RST; start while busy=1 SHALL be ignored.
REQ-018 DUT_RST: hold dut_rst_n=0 for exactly RST_CYCLES cycles, then go to FILL, or to DONE if num_vectors=0.
REQ-019 dut_rst_n SHALL be 0 in IDLE and DUT_RST and 1 in FILL, APPLY, SAMPLE and DONE.
REQ-020 LCG: next = (state*32'h41C64E6D + 32'h3039) mod 2^32; the word emitted is the new state.
REQ-021 FILL: generate one LCG word per cycle for NWORDS = ceil(IN_W/32) cycles.
REQ-022 FILL: word k goes to staging bits [32k+31:32k]; the last word is truncated to its low IN_W-32*(NWORDS-1) bits.
REQ-023 The LCG state SHALL carry over between vectors and SHALL NOT reseed within a run.
REQ-024 APPLY: load dut_in from staging in one cycle, with all bits changing together; dut_in SHALL hold otherwise.
REQ-025 SAMPLE: fold dut_out by XOR of its 32-bit slices, with the top slice zero-padded.
REQ-026 SAMPLE: signature <= {signature[30:0], signature[31]^signature[21]^signature[1]^signature[0]} ^ fold.
REQ-027 SAMPLE: vec_count increments by 1, then go to FILL if vec_count+1 < num_vectors, else to DONE.
REQ-028 Per-vector period SHALL be NWORDS+2 cycles; for the defaults that is 13 cycles.
REQ-029 DONE: done=1 for one cycle, then go to IDLE; vec_count, signature and dut_in SHALL hold until the next start.
REQ-030 num_vectors=65535 SHALL run to completion with no counter wrap.

Reset
REQ-031 rst=1 SHALL force IDLE in the next cycle from any state, abandoning any run in progress.
REQ-032 Reset values SHALL be: dut_rst_n=0, dut_in=0, busy=0, done=0, vec_count=0, signature=0, LCG state=0, staging=0.
REQ-033 rst SHALL take priority over start in the same cycle.

Structure
REQ-034 A shared package stim_pkg SHALL hold the LCG_MULT and LCG_INC constants, the WORD_W=32 constant, the state enum type and the MISR tap constant.
REQ-035 One sub-module, stim_lcg, SHALL hold the LCG state register and expose load, step, seed and word.

Verification
REQ-036 seed=0, num_vectors=1, defaults: first FILL word = 32'h00003039, dut_rst_n low for 2 cycles, done exactly 1+2+13 cycles after start, vec_count=1.
REQ-037 seed=1: first FILL word = 32'h41C67EA6; with dut_out tied to 0, signature stays 0 after 3 vectors.
REQ-038 num_vectors=0: DUT_RST lasts 2 cycles, then done pulses, vec_count=0 and dut_in is unchanged.
REQ-039 Raise start on every cycle of a run: exactly one run occurs, with one done pulse.
REQ-040 Assert rst during FILL of vector 2: next cycle busy=0, dut_rst_n=0, vec_count=0; a fresh start with the same seed reproduces the vector-1 dut_in exactly.
REQ-041 Same seed run twice with a deterministic DUT model: identical signature and identical dut_in sequence on both runs.

Source files
------------

// File: rtl/stim_pkg.sv
`default_nettype none
// ============================================================================
// Module      : stim_pkg
// Description : Shared constants, state encoding and MISR helper for the
//               stimulus sequencer (LCG constants, word width, MISR taps).
// Revision    : 1.0 - initial release
// ============================================================================
package stim_pkg;

  localparam int          WORD_W    = 32;
  localparam logic [31:0] LCG_MULT  = 32'h41C6_4E6D;
  localparam logic [31:0] LCG_INC   = 32'h0000_3039;
  // Feedback taps at bits 31, 21, 1 and 0 of the signature register.
  localparam logic [31:0] MISR_TAPS = 32'h8020_0003;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_DUT_RST = 3'd1,
    ST_FILL    = 3'd2,
    ST_APPLY   = 3'd3,
    ST_SAMPLE  = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

  // One MISR step: shift left, feed back the XOR of the tapped bits into
  // bit 0, then absorb the folded response word.
  function automatic logic [31:0] misr_step(input logic [31:0] sig,
                                            input logic [31:0] fold);
    return {sig[30:0], ^(sig & MISR_TAPS)} ^ fold;
  endfunction

endpackage
`default_nettype wire

// File: rtl/stim_lcg.sv
`default_nettype none
// ============================================================================
// Module      : stim_lcg
// Description : 32-bit linear congruential generator. o_word is the value the
//               state will take on the next step, so the word emitted by a
//               step is the new state.
// Ports       : clk, rst    - clock, synchronous active-high reset
//               i_load      - load i_seed into the state
//               i_step      - advance the state by one LCG iteration
//               i_seed      - seed value
//               o_word      - next LCG state (emitted word)
// Revision    : 1.0 - initial release
// ============================================================================
module stim_lcg
  import stim_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_load,
  input  logic        i_step,
  input  logic [31:0] i_seed,
  output logic [31:0] o_word
);

  logic [31:0] r_state;
  logic [31:0] w_next;

  assign w_next = (r_state * LCG_MULT) + LCG_INC;
  assign o_word = w_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= '0;
    end else if (i_load) begin
      r_state <= i_seed;
    end else if (i_step) begin
      r_state <= w_next;
    end
  end

endmodule
`default_nettype wire

// File: rtl/stim_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : stim_sequencer
// Description : Drives pseudo-random stimulus vectors into a DUT and
//               compacts its responses into a 32-bit MISR signature.
// Ports       : clk, rst      - clock, synchronous active-high reset
//               start         - run request (sampled only in IDLE)
//               seed          - LCG seed captured on start
//               num_vectors   - vectors per run captured on start
//               dut_rst_n     - active-low DUT reset
//               dut_in        - stimulus vector
//               dut_out       - DUT response
//               busy, done    - status (done is a one-cycle pulse)
//               vec_count     - vectors applied in current/last run
//               signature     - response signature
// Revision    : 1.0 - initial release
// ============================================================================
module stim_sequencer
  import stim_pkg::*;
#(
  parameter int IN_W       = 335,
  parameter int OUT_W      = 412,
  parameter int RST_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [31:0]      seed,
  input  logic [15:0]      num_vectors,
  output logic             dut_rst_n,
  output logic [IN_W-1:0]  dut_in,
  input  logic [OUT_W-1:0] dut_out,
  output logic             busy,
  output logic             done,
  output logic [15:0]      vec_count,
  output logic [31:0]      signature
);

  localparam int NWORDS  = (IN_W + WORD_W - 1) / WORD_W;
  localparam int LAST_IW = IN_W - WORD_W * (NWORDS - 1);
  localparam int NSLICE  = (OUT_W + WORD_W - 1) / WORD_W;
  localparam int LAST_OW = OUT_W - WORD_W * (NSLICE - 1);
  localparam int WI_W    = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam int RC_W    = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [RC_W-1:0]   r_rst_cnt;
  logic [WI_W-1:0]   r_widx;
  logic [15:0]       r_num;
  logic [15:0]       r_vec;
  logic [31:0]       r_sig;
  logic [IN_W-1:0]   r_stage;
  logic [IN_W-1:0]   r_dut_in;

  logic              w_lcg_load;
  logic              w_lcg_step;
  logic [31:0]       w_lcg_word;
  logic [IN_W-1:0]   w_stage_nxt;
  logic [31:0]       w_slice [NSLICE];
  logic [31:0]       w_fold;
  logic              w_rst_last;
  logic              w_word_last;
  logic              w_more;

  stim_lcg u_lcg (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_lcg_load),
    .i_step (w_lcg_step),
    .i_seed (seed),
    .o_word (w_lcg_word)
  );

  assign w_rst_last  = (r_rst_cnt == RC_W'(RST_CYCLES - 1));
  assign w_word_last = (r_widx == WI_W'(NWORDS - 1));
  // 17-bit compare so num_vectors = 65535 cannot wrap the count.
  assign w_more      = (({1'b0, r_vec} + 17'd1) < {1'b0, r_num});

  // Staging update: only the word selected by r_widx takes the LCG output;
  // the top word is truncated to the bits that exist.
  for (genvar k = 0; k < NWORDS; k++) begin : g_stage
    if (k < NWORDS - 1) begin : g_full
      assign w_stage_nxt[k*WORD_W +: WORD_W] =
        (r_widx == WI_W'(k)) ? w_lcg_word : r_stage[k*WORD_W +: WORD_W];
    end else begin : g_last
      assign w_stage_nxt[IN_W-1 : k*WORD_W] =
        (r_widx == WI_W'(k)) ? w_lcg_word[LAST_IW-1:0] : r_stage[IN_W-1 : k*WORD_W];
    end
  end

  // Response slices; the top slice is zero-padded when OUT_W is not a
  // multiple of the word width.
  for (genvar g = 0; g < NSLICE; g++) begin : g_slice
    if (g < NSLICE - 1) begin : g_mid
      assign w_slice[g] = dut_out[g*WORD_W +: WORD_W];
    end else if (LAST_OW == WORD_W) begin : g_top_full
      assign w_slice[g] = dut_out[OUT_W-1 -: WORD_W];
    end else begin : g_top_pad
      assign w_slice[g] = {{(WORD_W - LAST_OW){1'b0}}, dut_out[OUT_W-1 : g*WORD_W]};
    end
  end

  always_comb begin
    w_fold = '0;
    for (int i = 0; i < NSLICE; i++) begin
      w_fold = w_fold ^ w_slice[i];
    end
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM: next state and LCG control
  always_comb begin
    w_state_nxt = r_state;
    w_lcg_load  = 1'b0;
    w_lcg_step  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_lcg_load  = 1'b1;
          w_state_nxt = ST_DUT_RST;
        end
      end
      ST_DUT_RST: begin
        if (w_rst_last) begin
          w_state_nxt = (r_num == 16'd0) ? ST_DONE : ST_FILL;
        end
      end
      ST_FILL: begin
        w_lcg_step = 1'b1;
        if (w_word_last) begin
          w_state_nxt = ST_APPLY;
        end
      end
      ST_APPLY:  w_state_nxt = ST_SAMPLE;
      ST_SAMPLE: w_state_nxt = w_more ? ST_FILL : ST_DONE;
      ST_DONE:   w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rst_cnt <= '0;
      r_widx    <= '0;
      r_num     <= '0;
      r_vec     <= '0;
      r_sig     <= '0;
      r_stage   <= '0;
      r_dut_in  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_num     <= num_vectors;
            r_vec     <= '0;
            r_sig     <= '0;
            r_rst_cnt <= '0;
            r_widx    <= '0;
          end
        end
        ST_DUT_RST: r_rst_cnt <= r_rst_cnt + RC_W'(1);
        ST_FILL: begin
          r_stage <= w_stage_nxt;
          r_widx  <= w_word_last ? '0 : r_widx + WI_W'(1);
        end
        ST_APPLY: r_dut_in <= r_stage;
        ST_SAMPLE: begin
          r_sig <= misr_step(r_sig, w_fold);
          r_vec <= r_vec + 16'd1;
        end
        default: ;
      endcase
    end
  end

  assign busy      = (r_state != ST_IDLE);
  assign done      = (r_state == ST_DONE);
  assign dut_rst_n = !((r_state == ST_IDLE) || (r_state == ST_DUT_RST));
  assign dut_in    = r_dut_in;
  assign vec_count = r_vec;
  assign signature = r_sig;

endmodule
`default_nettype wire

// File: tb/tb_stim_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_stim_sequencer
// Description : Scoreboard bench for stim_sequencer. Each run request pushes
//               its expected final vec_count/signature/dut_in; a monitor pops
//               and compares on every done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stim_sequencer;

  localparam int IN_W  = 335;
  localparam int OUT_W = 412;
  localparam int NW    = 11;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [31:0]      seed;
  logic [15:0]      num;
  logic             dut_rst_n;
  logic [IN_W-1:0]  dut_in;
  logic [OUT_W-1:0] dut_out;
  logic             busy;
  logic             done;
  logic [15:0]      vec_count;
  logic [31:0]      signature;
  logic             tie0;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [15:0]     vc;
    logic [31:0]     sig;
    logic [IN_W-1:0] din;
  } exp_t;

  exp_t            q[$];
  exp_t            mon_e;
  logic [IN_W-1:0] vec_q[$];
  logic [IN_W-1:0] last_din;

  always #5 clk = ~clk;

  stim_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .seed        (seed),
    .num_vectors (num),
    .dut_rst_n   (dut_rst_n),
    .dut_in      (dut_in),
    .dut_out     (dut_out),
    .busy        (busy),
    .done        (done),
    .vec_count   (vec_count),
    .signature   (signature)
  );

  // Deterministic DUT stand-in: rotate-style replication plus a fixed
  // inversion pattern.
  function automatic logic [OUT_W-1:0] dut_model(input logic [IN_W-1:0] v);
    logic [OUT_W-1:0] o;
    o = {v[76:0], v};
    for (int i = 0; i < OUT_W; i++) begin
      if (i % 7 == 3) o[i] = ~o[i];
    end
    return o;
  endfunction

  assign dut_out = tie0 ? {OUT_W{1'b0}} : dut_model(dut_in);

  function automatic logic [31:0] lcg(input logic [31:0] s);
    return s * 32'h41C64E6D + 32'h00003039;
  endfunction

  task automatic check(input string nm, input logic [511:0] act, input logic [511:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_run(input logic [31:0] sd, input int n, input logic z, output exp_t e);
    logic [31:0]      st;
    logic [31:0]      fold;
    logic [31:0]      sig;
    logic [NW*32-1:0] wide;
    logic [IN_W-1:0]  v;
    logic [OUT_W-1:0] o;
    st = sd; sig = '0; wide = '0; e.din = last_din;
    vec_q.delete();
    for (int j = 0; j < n; j++) begin
      for (int k = 0; k < NW; k++) begin
        st = lcg(st);
        wide[k*32 +: 32] = st;
      end
      v = wide[IN_W-1:0];
      vec_q.push_back(v);
      o = z ? '0 : dut_model(v);
      fold = '0;
      for (int i = 0; i < OUT_W; i++) fold[i % 32] = fold[i % 32] ^ o[i];
      sig = {sig[30:0], sig[31] ^ sig[21] ^ sig[1] ^ sig[0]} ^ fold;
      e.din = v;
    end
    e.sig = sig;
    e.vc  = 16'(n);
  endtask

  task automatic issue(input logic [31:0] sd, input logic [15:0] n, input logic z);
    exp_t e;
    model_run(sd, int'(n), z, e);
    q.push_back(e);
    last_din = e.din;
    tie0 = z;
    @(posedge clk); #1;
    start = 1'b1; seed = sd; num = n;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Counts negedges from the accepting edge until done; checks each applied
  // vector against the model and optionally the low word at one cycle.
  task automatic wait_done(input int chk_cyc, input logic [31:0] chk_word, input string nm,
                           output int cyc, output int rl);
    int j;
    cyc = 0; rl = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (!dut_rst_n) rl++;
      if (cyc == chk_cyc) check(nm, dut_in[31:0], chk_word);
      if (cyc >= 15 && (cyc - 15) % 13 == 0) begin
        j = (cyc - 15) / 13;
        if (j < vec_q.size()) check("dut_in_vec", dut_in, vec_q[j]);
      end
    end while (done !== 1'b1 && cyc < 2000);
    if (done !== 1'b1) check("done_timeout", 0, 1);
  endtask

  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_done: got done=1 expected no pulse");
      end else begin
        mon_e = q.pop_front();
        check("vec_count", vec_count, mon_e.vc);
        check("signature", signature, mon_e.sig);
        check("dut_in_final", dut_in, mon_e.din);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   cyc, rl, ndone;
    exp_t e;
    rst = 1'b1; start = 1'b0; seed = '0; num = '0; tie0 = 1'b0; last_din = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_dut_rst_n", dut_rst_n, 0);
    check("rst_dut_in", dut_in, 0);
    check("rst_vec_count", vec_count, 0);
    check("rst_signature", signature, 0);
    @(posedge clk); #1; rst = 1'b0;

    // seed 0, one vector: latency and DUT reset width
    issue(32'd0, 16'd1, 1'b0);
    wait_done(15, 32'h0000_3039, "first_word_seed0", cyc, rl);
    check("latency_n1", cyc, 16);
    check("dut_rst_low_n1", rl, 2);
    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("idle_busy", busy, 0);

    // seed 1, three vectors, response tied to zero
    issue(32'd1, 16'd3, 1'b1);
    wait_done(15, 32'h41C6_7EA6, "first_word_seed1", cyc, rl);
    check("latency_n3", cyc, 42);
    check("sig_tied0", signature, 0);

    // zero vectors: reset phase then done, dut_in untouched
    issue(32'h0000_1234, 16'd0, 1'b0);
    wait_done(0, 32'd0, "none", cyc, rl);
    check("latency_n0", cyc, 3);
    check("dut_rst_low_n0", rl, 2);

    // start held high for the whole run; seed/num wiggle while busy
    model_run(32'd5, 2, 1'b0, e);
    q.push_back(e); last_din = e.din; tie0 = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; seed = 32'd5; num = 16'd2;
    ndone = 0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (c >= 2) begin
        seed = $urandom;
        num  = 16'($urandom_range(1, 9));
      end
      if (done === 1'b1) begin
        ndone++;
        start = 1'b0;
      end
    end
    start = 1'b0;
    check("start_held_runs", ndone, 1);

    // reset during FILL of vector 2, then rerun same seed
    issue(32'd7, 16'd3, 1'b0);
    for (int c = 1; c <= 18; c++) begin
      @(negedge clk);
      if (c == 15) check("abort_vec1", dut_in, vec_q[0]);
    end
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_dut_rst_n", dut_rst_n, 0);
    check("abort_vec_count", vec_count, 0);
    rst = 1'b0;
    e = q.pop_back();
    last_din = '0;
    issue(32'd7, 16'd1, 1'b0);
    wait_done(0, 32'd0, "none", cyc, rl);
    check("latency_rerun", cyc, 16);

    // same seed twice with the model DUT
    issue(32'hDEAD_BEEF, 16'd4, 1'b0);
    wait_done(0, 32'd0, "none", cyc, rl);
    issue(32'hDEAD_BEEF, 16'd4, 1'b0);
    wait_done(0, 32'd0, "none", cyc, rl);
    check("latency_n4", cyc, 55);

    repeat (5) @(negedge clk);
    check("queue_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
